// File: rtl/vga_fb_scan_if.sv
// Frame-buffer read port as seen from the VGA scan-out stage.
// No handshake: the scanner issues addr_out every clk and data_in returns one clk later.
interface vga_fb_scan_if #(
   parameter int AW = 15,
   parameter int DW = 3
);
   logic [AW-1:0] addr_out;
   logic [DW-1:0] data_in;

   modport master (output addr_out, input data_in);
   modport slave  (input addr_out, output data_in);
endinterface

// File: rtl/vga_fb_scan.sv
// VGA 640x480@60 scan-out: timing counters, 4x upscaled frame-buffer addressing,
// and a 3-stage pipeline that keeps rgb, syncs, de, vblank and frame_start aligned.
module vga_fb_scan #(
   parameter int AW          = 15,
   parameter int DW          = 3,
   parameter int FB_W        = 160,
   parameter int SCALE_SHIFT = 2,
   parameter int H_VIS       = 640,
   parameter int H_FP        = 16,
   parameter int H_SYNC      = 96,
   parameter int H_BP        = 48,
   parameter int V_VIS       = 480,
   parameter int V_FP        = 10,
   parameter int V_SYNC      = 2,
   parameter int V_BP        = 33
) (
   input  logic             clk,
   input  logic             reset,
   vga_fb_scan_if.master    fb,
   output logic [DW-1:0]    rgb,
   output logic             hsync,
   output logic             vsync,
   output logic             de,
   output logic             frame_start,
   output logic             vblank
);
   localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
   localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;

   typedef struct packed {
      logic vis;
      logic hs;
      logic vs;
      logic vb;
      logic fs;
   } ctl_t;

   // Syncs are active low, so the idle control word keeps them high.
   localparam ctl_t CTL_IDLE = '{vis: 1'b0, hs: 1'b1, vs: 1'b1, vb: 1'b0, fs: 1'b0};

   logic [9:0]    h_cnt_q, h_cnt_d;
   logic [9:0]    v_cnt_q, v_cnt_d;
   logic [AW-1:0] addr_q, addr_d;
   ctl_t          ctl0;
   ctl_t          ctl1_q, ctl1_d;
   ctl_t          ctl2_q, ctl2_d;
   ctl_t          ctl3_q, ctl3_d;
   logic [DW-1:0] rgb_q, rgb_d;

   always_comb begin
      h_cnt_d = h_cnt_q + 10'd1;
      v_cnt_d = v_cnt_q;
      if (h_cnt_q == 10'(H_TOT - 1)) begin
         h_cnt_d = '0;
         v_cnt_d = (v_cnt_q == 10'(V_TOT - 1)) ? '0 : v_cnt_q + 10'd1;
      end
   end

   always_comb begin
      ctl0.vis = (h_cnt_q < 10'(H_VIS)) && (v_cnt_q < 10'(V_VIS));
      ctl0.hs  = !((h_cnt_q >= 10'(H_VIS + H_FP)) && (h_cnt_q < 10'(H_VIS + H_FP + H_SYNC)));
      ctl0.vs  = !((v_cnt_q >= 10'(V_VIS + V_FP)) && (v_cnt_q < 10'(V_VIS + V_FP + V_SYNC)));
      ctl0.vb  = (v_cnt_q >= 10'(V_VIS));
      ctl0.fs  = (h_cnt_q == '0) && (v_cnt_q == '0);
   end

   // Address only advances on visible pixels, so it freezes on the line's last pixel in blanking.
   always_comb begin
      addr_d = addr_q;
      if (ctl0.vis) begin
         addr_d = AW'(AW'(v_cnt_q >> SCALE_SHIFT) * AW'(FB_W) + AW'(h_cnt_q >> SCALE_SHIFT));
      end
      ctl1_d = ctl0;
      ctl2_d = ctl1_q;
      ctl3_d = ctl2_q;
      rgb_d  = ctl2_q.vis ? fb.data_in : '0;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         h_cnt_q <= '0;
         v_cnt_q <= '0;
         addr_q  <= '0;
         ctl1_q  <= CTL_IDLE;
         ctl2_q  <= CTL_IDLE;
         ctl3_q  <= CTL_IDLE;
         rgb_q   <= '0;
      end else begin
         h_cnt_q <= h_cnt_d;
         v_cnt_q <= v_cnt_d;
         addr_q  <= addr_d;
         ctl1_q  <= ctl1_d;
         ctl2_q  <= ctl2_d;
         ctl3_q  <= ctl3_d;
         rgb_q   <= rgb_d;
      end
   end

   assign fb.addr_out  = addr_q;
   assign rgb          = rgb_q;
   assign hsync        = ctl3_q.hs;
   assign vsync        = ctl3_q.vs;
   assign de           = ctl3_q.vis;
   assign vblank       = ctl3_q.vb;
   assign frame_start  = ctl3_q.fs;
endmodule

// File: tb/tb_vga_fb_scan.sv
// Bench for vga_fb_scan: full horizontal timing, vertical timing shortened to keep frames short,
// synchronous buffer model, and a delay-line scoreboard of expected output words.
module tb_vga_fb_scan;
   localparam int AW = 15, DW = 3, FB_W = 160;
   localparam int H_VIS = 640, H_FP = 16, H_SYNC = 96, H_BP = 48;
   localparam int V_VIS = 20, V_FP = 2, V_SYNC = 2, V_BP = 3;
   localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
   localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
   localparam logic [7:0] BLANK = 8'b000_11_0_0_0;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic [DW-1:0] rgb;
   logic          hsync, vsync, de, frame_start, vblank;
   logic [2:0]    ram [0:1023];

   int n_chk = 0;
   int n_err = 0;

   vga_fb_scan_if #(.AW(AW), .DW(DW)) fb_if ();

   vga_fb_scan #(
      .AW(AW), .DW(DW), .FB_W(FB_W), .SCALE_SHIFT(2),
      .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
      .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
   ) dut (
      .clk(clk), .reset(reset), .fb(fb_if),
      .rgb(rgb), .hsync(hsync), .vsync(vsync), .de(de),
      .frame_start(frame_start), .vblank(vblank)
   );

   // clock / reset
   always #5 clk = ~clk;

   // registered-read frame buffer
   always @(posedge clk) fb_if.data_in <= ram[fb_if.addr_out[9:0]];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_chk++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, want, $time);
      end
   endtask

   function automatic logic [7:0] exp_pix(input int h, input int v);
      logic       vis, hs, vs;
      logic [2:0] r;
      vis = (h < H_VIS) && (v < V_VIS);
      hs  = !((h >= H_VIS + H_FP) && (h < H_VIS + H_FP + H_SYNC));
      vs  = !((v >= V_VIS + V_FP) && (v < V_VIS + V_FP + V_SYNC));
      r   = vis ? ram[(v >> 2) * FB_W + (h >> 2)] : 3'b000;
      return {r, hs, vs, vis, (h == 0 && v == 0), (v >= V_VIS)};
   endfunction

   // reference model of counter position and stage-1 address
   logic [7:0]    exp_q[$];
   int            m_h, m_v, prev_h, prev_v, rel_cnt;
   logic [AW-1:0] m_addr;
   bit            rst_seen;

   always @(posedge clk) begin
      if (!reset) begin
         m_h = 0; m_v = 0; m_addr = '0;
         prev_h = -1; prev_v = -1; rel_cnt = 0; rst_seen = 1;
         exp_q.delete();
         repeat (3) exp_q.push_back(BLANK);
      end else begin
         if (m_h < H_VIS && m_v < V_VIS) m_addr = AW'((m_v >> 2) * FB_W + (m_h >> 2));
         prev_h = m_h; prev_v = m_v; rel_cnt++;
         if (m_h == H_TOT - 1) begin
            m_h = 0;
            m_v = (m_v == V_TOT - 1) ? 0 : m_v + 1;
         end else begin
            m_h++;
         end
      end
   end

   // scoreboard and timing measurements
   int   cyc = 0;
   int   hs_fall_cyc, de_rise_cyc, fs_cyc, hs_len, de_len, vs_len, vb_len;
   bit   hs_ok, de_ok, vs_ok, vb_ok;
   logic prev_hs = 1'b1, prev_vs = 1'b1, prev_de = 1'b0, prev_vb = 1'b0;
   logic [7:0] want_w;

   always @(negedge clk) begin
      cyc++;
      if (rst_seen) begin
         hs_fall_cyc = -1; de_rise_cyc = -1; fs_cyc = -1;
         hs_ok = 0; de_ok = 0; vs_ok = 0; vb_ok = 0;
         rst_seen = 0;
      end
      check("addr", 32'(fb_if.addr_out), 32'(m_addr));
      if (prev_h >= 0 && prev_h < 4 && prev_v < 4) check("addr_origin", 32'(fb_if.addr_out), 0);
      if (prev_h == 4 && prev_v == 0) check("addr_h4", 32'(fb_if.addr_out), 1);
      if (prev_h == 0 && prev_v == 4) check("addr_v4", 32'(fb_if.addr_out), 160);
      if (prev_h == H_VIS - 1 && prev_v == V_VIS - 1) check("addr_last", 32'(fb_if.addr_out), 799);
      if (prev_h >= H_VIS && prev_v >= 0 && prev_v < V_VIS)
         check("addr_hold", 32'(fb_if.addr_out), 32'((prev_v >> 2) * 160 + 159));

      exp_q.push_back(exp_pix(m_h, m_v));
      if (exp_q.size() > 3) begin
         want_w = exp_q.pop_front();
         check("pix", 32'({rgb, hsync, vsync, de, frame_start, vblank}), 32'(want_w));
      end

      if (prev_hs && !hsync) begin
         if (hs_fall_cyc >= 0) check("hs_period", cyc - hs_fall_cyc, H_TOT);
         if (de_rise_cyc >= 0 && cyc - de_rise_cyc < H_TOT)
            check("hs_start", cyc - de_rise_cyc, H_VIS + H_FP);
         hs_fall_cyc = cyc; hs_len = 0; hs_ok = 1;
      end
      if (!hsync) hs_len++;
      if (!prev_hs && hsync && hs_ok) check("hs_width", hs_len, H_SYNC);

      if (!prev_de && de) begin de_rise_cyc = cyc; de_len = 0; de_ok = 1; end
      if (de) de_len++;
      if (prev_de && !de && de_ok) check("de_len", de_len, H_VIS);

      if (prev_vs && !vsync) begin vs_len = 0; vs_ok = 1; end
      if (!vsync) vs_len++;
      if (!prev_vs && vsync && vs_ok) check("vs_width", vs_len, V_SYNC * H_TOT);

      if (!prev_vb && vblank) begin vb_len = 0; vb_ok = 1; end
      if (vblank) vb_len++;
      if (prev_vb && !vblank && vb_ok) check("vblank_len", vb_len, (V_TOT - V_VIS) * H_TOT);

      if (frame_start) begin
         if (fs_cyc >= 0) check("frame_period", cyc - fs_cyc, H_TOT * V_TOT);
         else check("fs_latency", rel_cnt, 3);
         fs_cyc = cyc;
      end
      prev_hs = hsync; prev_vs = vsync; prev_de = de; prev_vb = vblank;
   end

   // driver tasks
   task automatic do_reset(input int n, input bit randomize_ram);
      @(negedge clk);
      reset = 1'b0;
      if (randomize_ram)
         for (int i = 0; i < 1024; i++) ram[i] = 3'($urandom_range(0, 7));
      repeat (n) @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic wait_pos(input int h, input int v, input int budget);
      bit found = 0;
      for (int i = 0; i < budget && !found; i++) begin
         @(negedge clk);
         if (m_h == h && m_v == v) found = 1;
      end
      check("wait_pos", 32'(found), 1);
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) ram[i] = 3'b000;
      ram[161] = 3'b101;
      do_reset(5, 0);
      check("rst_rgb", 32'(rgb), 0);
      check("rst_syncs", 32'({hsync, vsync, de}), 32'(3'b110));
      repeat (H_TOT * V_TOT + 1400) @(negedge clk);

      // abort mid-frame with a single-clk reset
      wait_pos(300, 10, 30000);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      repeat (100) @(negedge clk);

      do_reset(3, 1);
      repeat (H_TOT * V_TOT + 1400) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
